// File: rtl/alu_pkg.sv
// Shared definitions for the integer execution unit.
//   alu_op_e    : 5-bit operation codes (codes 18..31 are treated as ADD)
//   alu_state_e : control FSM states of alu_muldiv
//   shamt_w()   : shift-amount width, clog2(XLEN), usable in localparams
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic int shamt_w(input int xlen);
    return $clog2(xlen);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide datapath.
//   start  : load operands (op 10..17, divide special cases excluded)
//   op     : operation code, only sampled with start
//   a, b   : rs1, rs2
//   flush  : abandon the current operation
//   done   : high in the last step cycle; result is valid in that cycle
//   result : sign-corrected result, combinational from the final step
// Operands are stored as magnitudes. The single 2*XLEN accumulator holds
// {partial product, multiplier} for multiply and {remainder, dividend ->
// quotient} for divide.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = shamt_w(XLEN);

  logic              busy;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   opb;
  logic              is_div;
  logic              neg;
  logic              sel_hi;

  logic              a_signed, b_signed, a_neg, b_neg, st_div;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     r_sh;
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   r_new;
  logic [XLEN-1:0]   half;
  logic              ge;

  // Operand decode at start. MULHSU: a signed, b unsigned.
  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    st_div   = (op >= OP_DIV);
  end

  // One step, plus the sign fix-up of the value the step produces.
  always_comb begin
    r_sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    ge      = (r_sh >= {1'b0, opb});
    r_new   = ge ? XLEN'(r_sh - {1'b0, opb}) : r_sh[XLEN-1:0];
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    if (is_div) acc_nxt = {r_new, acc[XLEN-2:0], ge};
    else        acc_nxt = {sum, acc[XLEN-1:1]};
    prod    = neg ? -acc_nxt : acc_nxt;
    half    = sel_hi ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    if (is_div) result = neg ? -half : half;
    else        result = sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  end

  assign done = busy && (cnt == CW'(XLEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg    <= 1'b0;
      sel_hi <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      opb    <= st_div ? mag_b : mag_a;
      acc    <= {{XLEN{1'b0}}, (st_div ? mag_a : mag_b)};
      is_div <= st_div;
      // Remainder follows the dividend; quotient and product follow a^b.
      neg    <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
      sel_hi <= st_div ? ((op == OP_REM) || (op == OP_REMU)) : (op != OP_MUL);
    end else if (busy) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Handshaked integer execution unit: RV32I/RV64I register-register ALU ops
// plus the M extension via muldiv_iter.
//   in_valid/in_ready/in_op/in_a/in_b/in_tag : issue side
//   out_valid/out_ready/out_result/out_tag   : writeback side
//   flush     : synchronous kill of anything in flight or held
//   dbg_state : current FSM state (alu_state_e)
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid holds its payload stable until that edge. in_ready is
// high only in IDLE, so the unit takes at most one op per two cycles.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       dbg_state
);

  localparam int SW = shamt_w(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_state_e       state, state_nxt;
  logic             accept, take;
  logic             is_md, is_div, div_zero, div_ovf, md_start, md_done;
  logic [SW-1:0]    shamt;
  logic [XLEN-1:0]  alu_res, special_res, md_result, result_q;
  logic [TAG_W-1:0] tag_q;

  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign out_result = result_q;
  assign out_tag    = tag_q;
  assign dbg_state  = state;

  always_comb begin
    accept   = in_valid && in_ready;
    take     = accept && !flush;
    is_md    = (in_op >= OP_MUL) && (in_op <= OP_REMU);
    is_div   = (in_op >= OP_DIV) && (in_op <= OP_REMU);
    div_zero = is_div && (in_b == '0);
    div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) && (in_a == MIN_NEG) && (in_b == '1);
    md_start = take && is_md && !div_zero && !div_ovf;
    // Division by zero: q = all ones, r = a. Overflow: q = a, r = 0.
    if (div_zero)
      special_res = ((in_op == OP_DIV) || (in_op == OP_DIVU)) ? '1 : in_a;
    else
      special_res = (in_op == OP_DIV) ? in_a : '0;
  end

  // Base ALU; shift amount masked to log2(XLEN) bits.
  always_comb begin
    shamt = in_b[SW-1:0];
    case (in_op)
      OP_SUB:  alu_res = in_a - in_b;
      OP_SLL:  alu_res = in_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SRL:  alu_res = in_a >> shamt;
      OP_SRA:  alu_res = $signed(in_a) >>> shamt;
      OP_OR:   alu_res = in_a | in_b;
      OP_AND:  alu_res = in_a & in_b;
      default: alu_res = in_a + in_b;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .start  (md_start),
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = md_start ? ST_ITER : ST_DONE;
      ST_ITER: if (md_done) state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  // Result/tag only change when entering DONE, so they stay stable while
  // the consumer applies backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      tag_q    <= '0;
    end else if (state == ST_IDLE && take) begin
      tag_q <= in_tag;
      if (!is_md)                   result_q <= alu_res;
      else if (div_zero || div_ovf) result_q <= special_res;
    end else if (state == ST_ITER && md_done && !flush) begin
      result_q <= md_result;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        flush, out_ready, in_valid32, in_valid64;
  logic [4:0]  in_op, in_tag;
  logic [63:0] in_a, in_b;

  logic        rdy32, vld32, rdy64, vld64;
  logic [31:0] res32;
  logic [63:0] res64;
  logic [4:0]  tag32, tag64;
  logic [1:0]  st32, st64;

  int n_vec = 0;
  int n_err = 0;

  alu_muldiv #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(rdy32),
    .in_op(in_op), .in_a(in_a[31:0]), .in_b(in_b[31:0]), .in_tag(in_tag),
    .flush(flush), .out_valid(vld32), .out_ready(out_ready),
    .out_result(res32), .out_tag(tag32), .dbg_state(st32)
  );

  alu_muldiv #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(rdy64),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush), .out_valid(vld64), .out_ready(out_ready),
    .out_result(res64), .out_tag(tag64), .dbg_state(st64)
  );

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic cur_ready(input bit w64);
    return w64 ? rdy64 : rdy32;
  endfunction
  function automatic logic cur_valid(input bit w64);
    return w64 ? vld64 : vld32;
  endfunction
  function automatic logic [63:0] cur_result(input bit w64);
    return w64 ? res64 : {32'h0, res32};
  endfunction
  function automatic logic [4:0] cur_tag(input bit w64);
    return w64 ? tag64 : tag32;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input bit w64, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag);
    int guard = 0;
    @(negedge clk);
    while (!cur_ready(w64) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("issue_timeout", 64'(guard), 64'd0);
    in_op = op; in_a = a; in_b = b; in_tag = tag;
    if (w64) in_valid64 = 1'b1; else in_valid32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
  endtask

  // Called at accept edge + 1; latency 1 means valid right after the accept.
  task automatic wait_result(input bit w64, input string name, input logic [63:0] exp,
                             input logic [4:0] tag, input int exp_lat);
    int lat = 1;
    while (!cur_valid(w64) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_res"}, cur_result(w64), exp);
    check({name, "_tag"}, 64'(cur_tag(w64)), 64'(tag));
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input bit w64, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp, input int exp_lat, input string name);
    issue(w64, op, a, b, tag);
    wait_result(w64, name, exp, tag, exp_lat);
    consume();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid32 = 1'b0; in_valid64 = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(rdy32), 64'd1);
    check("rst_valid", 64'(vld32), 64'd0);
    check("rst_result", 64'(res32), 64'd0);
    check("rst_tag", 64'(tag32), 64'd0);
    check("rst_state", 64'(st32), 64'(ST_IDLE));
    check("rst_ready64", 64'(rdy64), 64'd1);
    rst = 1'b0;

    // base ops, XLEN = 32
    run_op(0, OP_ADD,  64'h7FFFFFFF, 64'h1,        5'd1, 64'h80000000, 1, "add_ovf");
    run_op(0, OP_SLTU, 64'h1,        64'hFFFFFFFF, 5'd2, 64'h1,        1, "sltu");
    run_op(0, OP_SLT,  64'h1,        64'hFFFFFFFF, 5'd3, 64'h0,        1, "slt");
    run_op(0, OP_SRA,  64'h80000000, 64'h21,       5'd4, 64'hC0000000, 1, "sra_mask");
    run_op(0, OP_SRL,  64'h80000000, 64'h21,       5'd5, 64'h40000000, 1, "srl_mask");
    run_op(0, OP_SLL,  64'h1,        64'h21,       5'd6, 64'h2,        1, "sll_mask");
    run_op(0, OP_SUB,  64'h3,        64'h5,        5'd7, 64'hFFFFFFFE, 1, "sub");
    run_op(0, OP_AND,  64'hF0F0,     64'h0FF0,     5'd8, 64'h00F0,     1, "and");
    run_op(0, OP_OR,   64'hF0F0,     64'h0FF0,     5'd9, 64'hFFF0,     1, "or");
    run_op(0, 5'd25,   64'h3,        64'h4,        5'd10, 64'h7,       1, "op25_add");

    // multiply / divide, XLEN = 32
    run_op(0, OP_MULH,   64'h80000000, 64'h80000000, 5'd11, 64'h40000000, 33, "mulh");
    run_op(0, OP_MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 5'd12, 64'hFFFFFFFF, 33, "mulhsu");
    run_op(0, OP_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 5'd13, 64'hFFFFFFFE, 33, "mulhu");
    run_op(0, OP_MUL,    64'h3,        64'hFFFFFFFB, 5'd14, 64'hFFFFFFF1, 33, "mul");
    run_op(0, OP_DIV,    64'hFFFFFFF9, 64'h2,        5'd15, 64'hFFFFFFFD, 33, "div");
    run_op(0, OP_REM,    64'hFFFFFFF9, 64'h2,        5'd16, 64'hFFFFFFFF, 33, "rem");
    run_op(0, OP_REM,    64'h7,        64'hFFFFFFFE, 5'd17, 64'h1,        33, "rem_negdiv");
    run_op(0, OP_DIVU,   64'd100,      64'd7,        5'd18, 64'd14,       33, "divu");
    run_op(0, OP_REMU,   64'd100,      64'd7,        5'd19, 64'd2,        33, "remu");
    run_op(0, OP_DIVU,   64'h7,        64'h0,        5'd20, 64'hFFFFFFFF, 1,  "divu_zero");
    run_op(0, OP_REMU,   64'h7,        64'h0,        5'd21, 64'h7,        1,  "remu_zero");
    run_op(0, OP_DIV,    64'h80000000, 64'hFFFFFFFF, 5'd22, 64'h80000000, 1,  "div_ovf");
    run_op(0, OP_REM,    64'h80000000, 64'hFFFFFFFF, 5'd23, 64'h0,        1,  "rem_ovf");

    // backpressure
    issue(0, OP_XOR, 64'hF0F0, 64'h0FF0, 5'd24);
    wait_result(0, "bp_xor", 64'hFF00, 5'd24, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_result", 64'(res32), 64'hFF00);
      check("bp_tag", 64'(tag32), 64'd24);
      check("bp_ready", 64'(rdy32), 64'd0);
      check("bp_valid", 64'(vld32), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_op = OP_ADD; in_a = 64'd3; in_b = 64'd4; in_tag = 5'd25; in_valid32 = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_hs_valid", 64'(vld32), 64'd0);
    check("bp_hs_ready", 64'(rdy32), 64'd1);
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    check("bp_next_valid", 64'(vld32), 64'd1);
    check("bp_next_result", 64'(res32), 64'd7);
    check("bp_next_tag", 64'(tag32), 64'd25);
    consume();

    // flush 10 cycles into a DIVU
    issue(0, OP_DIVU, 64'd1000, 64'd7, 5'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_ready", 64'(rdy32), 64'd1);
    check("flush_valid", 64'(vld32), 64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (vld32) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    run_op(0, OP_ADD, 64'd3, 64'd4, 5'd12, 64'd7, 1, "post_flush_add");

    // flush in the accepting cycle
    @(negedge clk);
    in_op = OP_ADD; in_a = 64'd1; in_b = 64'd1; in_tag = 5'd3;
    in_valid32 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0; flush = 1'b0;
    check("flush_acc_valid", 64'(vld32), 64'd0);
    check("flush_acc_ready", 64'(rdy32), 64'd1);
    @(posedge clk); #1;
    check("flush_acc_valid2", 64'(vld32), 64'd0);

    // asynchronous reset mid-ITER (result/tag currently hold 7 / 12)
    issue(0, OP_MUL, 64'd3, 64'd5, 5'd7);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_ready", 64'(rdy32), 64'd1);
    check("arst_valid", 64'(vld32), 64'd0);
    check("arst_result", 64'(res32), 64'd0);
    check("arst_tag", 64'(tag32), 64'd0);
    check("arst_state", 64'(st32), 64'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;

    // XLEN = 64
    run_op(1, OP_MULH,   64'h8000000000000000, 64'h8000000000000000, 5'd1, 64'h4000000000000000, 65, "mulh64");
    run_op(1, OP_MULHSU, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd2, 64'hFFFFFFFFFFFFFFFF, 65, "mulhsu64");
    run_op(1, OP_MULHU,  64'h8000000000000000, 64'h4,                5'd3, 64'h2,                65, "mulhu64");
    run_op(1, OP_MUL,    64'h3,                64'hFFFFFFFFFFFFFFFB, 5'd4, 64'hFFFFFFFFFFFFFFF1, 65, "mul64");
    run_op(1, OP_DIV,    64'hFFFFFFFFFFFFFFF9, 64'h2,                5'd5, 64'hFFFFFFFFFFFFFFFD, 65, "div64");
    run_op(1, OP_REM,    64'hFFFFFFFFFFFFFFF9, 64'h2,                5'd6, 64'hFFFFFFFFFFFFFFFF, 65, "rem64");
    run_op(1, OP_DIVU,   64'h7,                64'h0,                5'd7, 64'hFFFFFFFFFFFFFFFF, 1,  "divu0_64");
    run_op(1, OP_DIV,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd8, 64'h8000000000000000, 1, "div_ovf64");
    run_op(1, OP_REM,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd9, 64'h0,                1,  "rem_ovf64");
    run_op(1, OP_SRA,    64'h8000000000000000, 64'h41,               5'd10, 64'hC000000000000000, 1, "sra64");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, handshaked integer execution unit for the RV32/RV64 core, replacing the purely combinational ALU. It covers RV32I/RV64I register-register ALU ops with corrected shift-amount masking and unsigned compare, plus the M extension through an iterative multiplier/divider. It sits between the decode/operand-read stage and writeback, and uses valid/ready on both sides so multi-cycle ops stall the pipeline cleanly.

## Interface
- XLEN, 32, operand/result width; 32 or 64.
- TAG_W, 5, width of the sideband tag (destination register index) passed from issue to result.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_op  in  5  operation code (see Operation).
- in_a, in_b  in  XLEN  operands rs1, rs2.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- flush  in  1  synchronous kill of any in-flight or pending op.
- out_valid  out  1  result available; held until consumed.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the op producing out_result.

## Operation
- Op codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU. Codes 18–31 behave as ADD.
- Shifts use only in_b[log2(XLEN)-1:0]. SRA is arithmetic. SLT is a signed compare and SLTU an unsigned compare. Both return 0 or 1, zero-extended.
- The transfer at the input is in_valid && in_ready. Operands, op and tag are latched on the accepting edge.
- FSM states:
  - IDLE: on accept, ops 0–9 compute combinationally, load the result register and go to DONE.
  - IDLE, ops 10–17: operands go to magnitudes per signedness, counter = 0, next state ITER. MULHSU treats a as signed and b as unsigned.
  - IDLE, divide special cases skip ITER and go to DONE directly:
    - divisor 0: quotient all-ones, remainder = dividend a.
    - DIV/REM with a = most-negative and b = −1: quotient = a, remainder = 0.
  - ITER: one radix-2 step per cycle. Multiply uses shift-add into a 2·XLEN accumulator. Divide is restoring, producing quotient and remainder.
  - ITER exit: after XLEN steps, the sign fix-up is applied combinationally and the result register is loaded. Next state is DONE.
    - MUL selects the low half of the product, MULH/MULHSU/MULHU the high half.
    - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - DONE: out_valid = 1. When out_ready is high, go to IDLE. No new op is accepted in the same cycle.
- flush has priority over all transitions. The next state is IDLE, out_valid drops next cycle and any held result is discarded.
- out_result and out_tag stay stable while out_valid && !out_ready.

## Timing
- Reset values:
  - state = IDLE, in_ready = 1.
  - out_valid = 0, out_result = 0, out_tag = 0.
  - counter and accumulators = 0.
- Ops 0–9 and divide special cases: out_valid in cycle N+1 for an accept in cycle N.
- Ops 10–17 otherwise: out_valid in cycle N+1+XLEN, i.e. cycle N+33 for XLEN = 32.
- Throughput: at best one op per 2 cycles, because in_ready is low in DONE.
- in_ready is a registered function of state only. It has no combinational path from out_ready.
- Reset mid-ITER: the unit returns to IDLE immediately. No result is produced.
- flush in the accepting cycle: the op is discarded.

## Structure
- A shared package `alu_pkg` holds:
  - the op-code enum (the 5-bit encodings above);
  - the FSM state enum (IDLE, ITER, DONE);
  - a localparam function for the shift-amount width, clog2(XLEN).
- One sub-module, `muldiv_iter`, contains the XLEN-step multiply/divide datapath, counter and sign fix-up. It has a start/done interface, and the top-level FSM drives it.
- The base ALU ops stay inline in `alu_muldiv`.

## Test plan
- Base ops, XLEN = 32:
  - ADD 0x7FFFFFFF + 1 → 0x80000000.
  - SLTU 1 vs 0xFFFFFFFF → 1; SLT of the same pair → 0.
  - SRA 0x80000000 by 0x21 → 0xC0000000 (shift amount masked to 1).
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF. Each has out_valid exactly 33 cycles after accept.
- DIV −7 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 7 / 0 → 0xFFFFFFFF with out_valid 1 cycle after accept. DIV 0x80000000 / −1 → 0x80000000 with REM 0.
- Backpressure: hold out_ready low for 5 cycles after a result.
  - out_result and out_tag stay stable and in_ready stays low.
  - The next accept occurs the cycle after the out_ready handshake.
- Pulse flush 10 cycles into a DIVU. out_valid never asserts, and in_ready is high the next cycle. A following ADD 3 + 4 returns 7 with its own tag.
- Assert rst asynchronously mid-ITER: all outputs reach reset values without a clock edge. Repeat the MUL/DIV checks with XLEN = 64, with out_valid at 65 cycles.
